// File: rtl/audio_pkg.sv
// audio_pkg: shared sample layout, silence constant and playback state encoding.
package audio_pkg;
    localparam int SAMPLE_W  = 32;
    localparam int LEFT_MSB  = 31;
    localparam int LEFT_LSB  = 16;
    localparam int RIGHT_MSB = 15;
    localparam int RIGHT_LSB = 0;
    localparam logic [SAMPLE_W-1:0] SILENCE = '0;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer plus history flop; one-cycle pulse on a falling edge.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic fall
);
    logic meta, sync, hist;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            hist <= 1'b0;
        end else begin
            meta <= async_in;
            sync <= meta;
            hist <= sync;
        end
    assign fall = hist & ~sync;
endmodule

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: DEPTH-entry sample FIFO feeding the I2S transmitter, one pop per SyncCLK frame.
// Define AUDIO_FIFO_UNDERRUN_CNT_EN to add the saturating UnderrunCount output.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int LOW_LEVEL = 4
) (
    input  logic                    MasterCLK,
    input  logic                    Resetn,
    input  logic [SAMPLE_W-1:0]     WrData,
    input  logic                    WrEn,
    input  logic                    Enable,
    input  logic                    ClearFlags,
    input  logic                    SyncCLK,
    output logic [SAMPLE_W-1:0]     InputData,
    output logic [$clog2(DEPTH):0]  Level,
    output logic                    Full,
    output logic                    Empty,
    output logic                    LowLevel,
    output logic                    Underrun,
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
    output logic                    Overflow,
    output logic [15:0]             UnderrunCount
`else
    output logic                    Overflow
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    state_t state;
    logic frame_req, wr_ok, ovf_set, active, pop, und_set;

    sync_edge_detect u_sync (
        .clk      (MasterCLK),
        .rst_n    (Resetn),
        .async_in (SyncCLK),
        .fall     (frame_req)
    );

    assign Full     = Level == LW'(DEPTH);
    assign Empty    = Level == '0;
    assign LowLevel = Level <= LW'(LOW_LEVEL);
    assign wr_ok    = WrEn & ~Full;
    assign ovf_set  = WrEn & Full;
    assign active   = (state == RUN) & Enable & frame_req;
    assign pop      = active & ~Empty;
    assign und_set  = active & Empty;

    // Storage is not reset: the pointers and Level define what is valid.
    always_ff @(posedge MasterCLK)
        if (wr_ok) mem[wr_ptr] <= WrData;

    always_ff @(posedge MasterCLK or negedge Resetn)
        if (!Resetn) begin
            state     <= IDLE;
            InputData <= SILENCE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            Level     <= '0;
            Underrun  <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                InputData <= SILENCE;
                if (Enable) state <= RUN;
            end else if (!Enable) begin
                state     <= IDLE;
                InputData <= SILENCE;
            end else if (frame_req)
                InputData <= pop ? mem[rd_ptr] : SILENCE;
            wr_ptr   <= wr_ptr + AW'(wr_ok);
            rd_ptr   <= rd_ptr + AW'(pop);
            Level    <= Level + LW'(wr_ok) - LW'(pop);
            Underrun <= und_set | (Underrun & ~ClearFlags);
            Overflow <= ovf_set | (Overflow & ~ClearFlags);
        end

`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
    always_ff @(posedge MasterCLK or negedge Resetn)
        if (!Resetn)
            UnderrunCount <= '0;
        else if (und_set)
            UnderrunCount <= ClearFlags ? 16'd1 :
                             (UnderrunCount == 16'hFFFF) ? UnderrunCount : UnderrunCount + 16'd1;
        else if (ClearFlags)
            UnderrunCount <= '0;
`endif
endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb_audio_sample_fifo: scenario tasks plus randomized traffic against a queue-based frame model.
module tb_audio_sample_fifo;
    localparam int DEPTH = 16;
    localparam int LOW   = 4;
    localparam int LW    = 5;
    localparam logic [41:0] RST = {32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    logic        MasterCLK = 0, Resetn = 0, WrEn = 0, Enable = 0, ClearFlags = 0, SyncCLK = 0;
    logic [31:0] WrData = 0;
    logic [31:0] InputData;
    logic [LW-1:0] Level;
    logic        Full, Empty, LowLevel, Underrun, Overflow;
    logic [41:0] obs;
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
    logic [15:0] UnderrunCount;
`endif

    int checks = 0, failures = 0, cyc_n = 0;

    always #5 MasterCLK = ~MasterCLK;

    audio_sample_fifo #(.DEPTH(DEPTH), .LOW_LEVEL(LOW)) dut (
        .MasterCLK  (MasterCLK),
        .Resetn     (Resetn),
        .WrData     (WrData),
        .WrEn       (WrEn),
        .Enable     (Enable),
        .ClearFlags (ClearFlags),
        .SyncCLK    (SyncCLK),
        .InputData  (InputData),
        .Level      (Level),
        .Full       (Full),
        .Empty      (Empty),
        .LowLevel   (LowLevel),
        .Underrun   (Underrun),
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
        .Overflow   (Overflow),
        .UnderrunCount (UnderrunCount)
`else
        .Overflow   (Overflow)
`endif
    );

    assign obs = {InputData, Level, Full, Empty, LowLevel, Underrun, Overflow};

    // Reference model: a frame request is seen at the edge whose two-back SyncCLK
    // sample is 0 and three-back sample is 1.
    logic [31:0] q[$];
    logic [31:0] m_out = 0;
    int          m_lvl = 0;
    logic        m_run = 0, m_und = 0, m_ovf = 0, fr, full_m, us;
    logic [2:0]  sh = 0;
    logic [15:0] m_cnt = 0;

    always @(posedge MasterCLK) begin
        if (!Resetn) begin
            q.delete();
            m_out = 0; m_run = 0; m_und = 0; m_ovf = 0; sh = 0; m_cnt = 0;
        end else begin
            fr = sh[2] & ~sh[1];
            sh = {sh[1:0], SyncCLK};
            full_m = q.size() == DEPTH;
            us = 0;
            if (!m_run) begin
                m_out = 0;
                m_run = Enable;
            end else if (!Enable) begin
                m_run = 0;
                m_out = 0;
            end else if (fr) begin
                if (q.size() > 0) m_out = q.pop_front();
                else begin
                    m_out = 0;
                    us = 1;
                end
            end
            if (WrEn && !full_m) q.push_back(WrData);
            m_und = us | (m_und & ~ClearFlags);
            m_ovf = (WrEn & full_m) | (m_ovf & ~ClearFlags);
            if (us) m_cnt = ClearFlags ? 16'd1 : (m_cnt == 16'hFFFF ? m_cnt : m_cnt + 16'd1);
            else if (ClearFlags) m_cnt = 0;
        end
        m_lvl = q.size();
    end

    function automatic logic [41:0] expv();
        return {m_out, LW'(m_lvl), m_lvl == DEPTH, m_lvl == 0, m_lvl <= LOW, m_und, m_ovf};
    endfunction

    task automatic cyc(input logic we, input logic [31:0] wd, input logic en, input logic clr, input logic sc);
        WrEn = we; WrData = wd; Enable = en; ClearFlags = clr; SyncCLK = sc;
        @(negedge MasterCLK);
        cyc_n++;
    endtask

    task automatic do_reset();
        Resetn = 0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        Resetn = 1;
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        Resetn = 0;
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (obs !== RST) begin failures++; $display("FAIL reset_values got=%h exp=%h", obs, RST); end
        Resetn = 1;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 0, 1);
            checks++;
            if (obs !== expv()) begin failures++; $display("FAIL reset_no_spurious cyc=%0d got=%h exp=%h", cyc_n, obs, expv()); end
        end
        checks++;
        if (Underrun !== 1'b0) begin failures++; $display("FAIL reset_high_sync underrun got=%b exp=0", Underrun); end
    endtask

    task automatic test_underrun();
        do_reset();
        for (int i = 0; i < 24; i++) begin
            cyc(0, 0, 1, 0, (i % 8) < 4);
            checks++;
            if (obs !== expv()) begin failures++; $display("FAIL underrun cyc=%0d got=%h exp=%h", cyc_n, obs, expv()); end
            if (i == 5 || i == 6) begin
                checks++;
                if (Underrun !== (i == 6)) begin failures++; $display("FAIL underrun_latency i=%0d got=%b exp=%b", i, Underrun, i == 6); end
            end
        end
        checks++;
        if ({InputData, Level} !== 37'h0) begin failures++; $display("FAIL underrun_silence got=%h/%0d exp=0/0", InputData, Level); end
    endtask

    task automatic test_order();
        do_reset();
        cyc(1, 32'h11112222, 1, 0, 1);
        cyc(1, 32'h33334444, 1, 0, 1);
        checks++;
        if (Level !== 5'd2) begin failures++; $display("FAIL order_level2 got=%0d exp=2", Level); end
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 1, 0, (i % 8) < 4);
            checks++;
            if (obs !== expv()) begin failures++; $display("FAIL order cyc=%0d got=%h exp=%h", cyc_n, obs, expv()); end
            if (i == 6) begin
                checks++;
                if ({InputData, Level} !== {32'h11112222, 5'd1}) begin failures++; $display("FAIL order_first got=%h/%0d exp=11112222/1", InputData, Level); end
            end
            if (i == 14) begin
                checks++;
                if ({InputData, Level} !== {32'h33334444, 5'd0}) begin failures++; $display("FAIL order_second got=%h/%0d exp=33334444/0", InputData, Level); end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cyc(1, $urandom, 0, 0, 1);
            checks++;
            if (obs !== expv()) begin failures++; $display("FAIL overflow_fill cyc=%0d got=%h exp=%h", cyc_n, obs, expv()); end
        end
        checks++;
        if ({Full, Overflow, Level} !== {1'b1, 1'b1, 5'd16}) begin failures++; $display("FAIL overflow_state got=%b%b/%0d exp=11/16", Full, Overflow, Level); end
        for (int i = 0; i < 17 * 8; i++) begin
            cyc(0, 0, 1, 0, (i % 8) < 4);
            checks++;
            if (obs !== expv()) begin failures++; $display("FAIL overflow_drain cyc=%0d got=%h exp=%h", cyc_n, obs, expv()); end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, $urandom, 1, 0, 1);
        for (int i = 0; i < 8; i++) begin
            cyc(i == 6, $urandom, 1, 0, i < 4);
            checks++;
            if (obs !== expv()) begin failures++; $display("FAIL simul_lvl5 cyc=%0d got=%h exp=%h", cyc_n, obs, expv()); end
        end
        checks++;
        if (Level !== 5'd5) begin failures++; $display("FAIL simul_level5 got=%0d exp=5", Level); end
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(i == 6, 32'hCAFEF00D, 1, 0, i < 4);
            checks++;
            if (obs !== expv()) begin failures++; $display("FAIL simul_lvl0 cyc=%0d got=%h exp=%h", cyc_n, obs, expv()); end
        end
        checks++;
        if ({Underrun, Level} !== {1'b1, 5'd1}) begin failures++; $display("FAIL simul_empty got=%b/%0d exp=1/1", Underrun, Level); end
    endtask

    task automatic test_enable();
        logic [31:0] d [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom | 32'h1;
            cyc(1, d[i], 1, 0, 1);
        end
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, i < 4);
        checks++;
        if ({InputData, Level} !== {d[0], 5'd3}) begin failures++; $display("FAIL enable_pop got=%h/%0d exp=%h/3", InputData, Level, d[0]); end
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (InputData !== 32'h0) begin failures++; $display("FAIL enable_off_silence got=%h exp=0", InputData); end
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 0, 0, (i % 8) < 4);
            checks++;
            if (obs !== expv()) begin failures++; $display("FAIL enable_idle cyc=%0d got=%h exp=%h", cyc_n, obs, expv()); end
        end
        checks++;
        if (Level !== 5'd3) begin failures++; $display("FAIL enable_hold got=%0d exp=3", Level); end
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 0, i < 4);
            checks++;
            if (obs !== expv()) begin failures++; $display("FAIL enable_resume cyc=%0d got=%h exp=%h", cyc_n, obs, expv()); end
        end
        checks++;
        if (InputData !== d[1]) begin failures++; $display("FAIL enable_oldest got=%h exp=%h", InputData, d[1]); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 17; i++) cyc(1, $urandom, 1, 0, 1);
        Resetn = 0;
        #1;
        checks++;
        if (obs !== RST) begin failures++; $display("FAIL mid_reset got=%h exp=%h", obs, RST); end
        cyc(0, 0, 0, 0, 1);
        Resetn = 1;
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (obs !== expv()) begin failures++; $display("FAIL mid_reset_release got=%h exp=%h", obs, expv()); end
    endtask

    task automatic test_random();
        logic sc = 1;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3) == 0) sc = ~sc;
            cyc($urandom_range(2) != 0, $urandom, $urandom_range(15) != 0, $urandom_range(15) == 0, sc);
            checks++;
            if (obs !== expv()) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc_n, obs, expv()); end
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
            checks++;
            if (UnderrunCount !== m_cnt) begin failures++; $display("FAIL random_count cyc=%0d got=%0d exp=%0d", cyc_n, UnderrunCount, m_cnt); end
`endif
        end
    endtask

`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
    task automatic test_count();
        do_reset();
        for (int i = 0; i < 40; i++) cyc(0, 0, 1, 0, (i % 8) < 4);
        checks++;
        if (UnderrunCount !== 16'd5) begin failures++; $display("FAIL count5 got=%0d exp=5", UnderrunCount); end
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, i == 6, i < 4);
        checks++;
        if ({UnderrunCount, Underrun} !== {16'd1, 1'b1}) begin failures++; $display("FAIL count_clear got=%0d/%b exp=1/1", UnderrunCount, Underrun); end
    endtask
`endif

    initial begin
        @(negedge MasterCLK);
        test_reset();
        test_underrun();
        test_order();
        test_overflow();
        test_simultaneous();
        test_enable();
        test_mid_reset();
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
        test_count();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/audio_sample_fifo.md
# audio_sample_fifo

Sample buffer directly upstream of the I2S transmitter. It accepts packed stereo samples from the audio/video peripheral's write side and holds them in a DEPTH-entry FIFO. It presents one sample per I2S frame on `InputData`, paced by the transmitter's `SyncCLK` output. On underrun it outputs silence and flags the event.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥4.
- `LOW_LEVEL`, 4: `LowLevel` asserts when `Level` ≤ this value.

Ports:
- `MasterCLK` in 1: the single clock; all logic on its rising edge.
- `Resetn` in 1: asynchronous, active-low reset.
- `WrData` in 32: sample; left channel in [31:16], right in [15:0].
- `WrEn` in 1: write strobe, one sample per cycle.
- `Enable` in 1: playback enable.
- `ClearFlags` in 1: clears `Underrun` and `Overflow`.
- `SyncCLK` in 1: from the I2S transmitter; asynchronous to `MasterCLK`.
- `InputData` out 32: sample to the I2S transmitter.
- `Level` out $clog2(DEPTH)+1: current occupancy.
- `Full` out 1, `Empty` out 1, `LowLevel` out 1: FIFO status.
- `Underrun` out 1: sticky flag.
- `Overflow` out 1: sticky flag.

## Operation
- **Write side**
  - `WrEn && !Full`: `WrData` is stored at the write pointer, and the write pointer increments modulo DEPTH.
  - `WrEn && Full`: data is dropped and `Overflow` is set.
  - `Full` comes from the registered `Level`. A write is rejected when full even if a pop happens in the same cycle.
- **Frame request**
  - `SyncCLK` passes through a 2-flop synchronizer plus one history flop.
  - A falling edge (history=1, sync=0) produces a one-cycle `FrameReq`.
  - This point is mid-frame, half a frame before the transmitter latches `InputData` on `SyncCLK` rising.
- **State machine** (2 states):
  - IDLE: `InputData` = 0, no pops, `Underrun` is never set. Go to RUN when `Enable`=1.
  - RUN: on `FrameReq`:
    - If `!Empty`: `InputData` ← head entry, read pointer increments modulo DEPTH.
    - If `Empty`: `InputData` ← 0 and `Underrun` is set.
  - RUN → IDLE when `Enable`=0. `InputData` is cleared to 0 on the next cycle. FIFO contents and pointers are preserved.
- **Level update**
  - Pop only: `Level` −1. Write only: `Level` +1. Both in the same cycle: unchanged.
  - Write to an empty FIFO in the same cycle as `FrameReq`: the pop sees empty, so underrun occurs and the write lands.
- **Flags**
  - `ClearFlags` clears `Underrun` and `Overflow`. If set and clear coincide in one cycle, set wins.
  - `Empty` = (`Level`==0). `Full` = (`Level`==DEPTH). `LowLevel` = (`Level` ≤ LOW_LEVEL).

## Timing
- Reset values:
  - `InputData`=0, `Level`=0, `Empty`=1, `Full`=0, `LowLevel`=1, `Underrun`=0, `Overflow`=0.
  - State IDLE, pointers 0.
  - Synchronizer and history flops reset to 0, so a high `SyncCLK` after reset gives no spurious request.
- `SyncCLK` fall to `InputData` update: 3 `MasterCLK` cycles (2 sync + 1 register).
- Write-to-`Level` latency: 1 cycle. A sample written at cycle N is poppable by a `FrameReq` at N+1.
- Reset asserted mid-operation: all state returns to reset values immediately. Buffered samples are discarded.
- Requirement: a `MasterCLK` period shorter than 1/4 of the `SyncCLK` half-period, so the fall-to-update latency fits well inside half a frame.

## Configuration
- `AUDIO_FIFO_UNDERRUN_CNT_EN` defined:
  - Adds output `UnderrunCount` (16 bits, reset 0).
  - Increments on every underrun event and saturates at 0xFFFF.
  - Cleared by `ClearFlags`. If a clear and an underrun coincide, the result is 1.
- Not defined: the port is absent. Only the sticky `Underrun` flag exists.

## Structure
- Shared package `audio_pkg`:
  - `SAMPLE_W`=32.
  - `LEFT_MSB`=31, `LEFT_LSB`=16, `RIGHT_MSB`=15, `RIGHT_LSB`=0.
  - Silence constant (32'h0).
  - State enum {IDLE, RUN}.
- One sub-module, `sync_edge_detect`: a 2-flop synchronizer plus falling-edge pulse, with async active-low reset. It is reusable for other I2S/video timing inputs.
- Storage is a register array. No RAM macro.

## Test plan
- Reset, then `Enable`=1 with no writes, then toggle `SyncCLK` → `InputData` stays 0, `Underrun`=1 after the first `SyncCLK` fall + 3 cycles, `Level`=0.
- Write 0x11112222, 0x33334444, then 2 `SyncCLK` falls → `InputData` = 0x11112222 then 0x33334444, each 3 cycles after its fall. `Level` goes 2→1→0.
- Write 17 samples into DEPTH=16 → `Full`=1, `Overflow`=1, `Level`=16. The 17th sample is never output.
- Write and `FrameReq` in the same cycle with `Level`=5 → `Level` stays 5; with `Level`=0 → `Underrun`=1, `Level`=1.
- Deassert `Enable` with `Level`=3 → `InputData`=0 next cycle, `Level` stays 3 across `SyncCLK` falls. Re-enable → output resumes with the oldest entry.
- With `AUDIO_FIFO_UNDERRUN_CNT_EN`: 5 frames on an empty FIFO → `UnderrunCount`=5. Then `ClearFlags` coinciding with a 6th underrun → `UnderrunCount`=1, `Underrun`=1.
